maxpool2x2_relu_stream: RTL and testbench

- Parametrised 2x2 / stride-2 max-pooling plus ReLU stage for the CNN feature-map pipeline.
- Sits between a convolution stage and the next layer; pixels arrive in raster order with CHANNELS lanes in parallel.
- Successor to the fixed 12-bit / 3-channel / 24-wide pooling stage: width, channel count and frame size are parameters.
- Adds valid/ready backpressure on both sides, odd-dimension handling, a frame-done pulse, and a compile-time ReLU bypass.

---
 rtl/maxpool2x2_relu_stream.sv | 110 +++++++++++
 tb/tb_maxpool2x2_relu_stream.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_relu_stream.sv
// 2x2 / stride-2 max-pooling stage with valid/ready streaming on both sides.
// Optional ReLU on the pooled result is enabled by defining MAXPOOL_RELU_EN.
module maxpool2x2_relu_stream #(
  parameter int DATA_W   = 12,
  parameter int CHANNELS = 3,
  parameter int IN_W     = 24,
  parameter int IN_H     = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         frame_done
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int COL_W = $clog2(IN_W);
  localparam int ROW_W = $clog2(IN_H);
  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic [CHANNELS*DATA_W-1:0]  line_buf [OUT_W];
  logic [CHANNELS*DATA_W-1:0]  buf_rd;
  logic [CHANNELS*DATA_W-1:0]  merged;
  logic [CHANNELS*DATA_W-1:0]  pooled;
  logic [IDX_W-1:0]            idx;
  logic                        accept;
  logic                        col_last;
  logic                        row_last;
  logic                        in_pool;
  logic                        window_end;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign col_last   = (col == COL_W'(IN_W - 1));
  assign row_last   = (row == ROW_W'(IN_H - 1));
  assign idx        = IDX_W'(col >> 1);
  assign window_end = row[0] && col[0];

  // Trailing odd column / odd row fall outside every 2x2 window.
  assign in_pool = ({1'b0, col} < (COL_W + 1)'(2 * OUT_W)) &&
                   ({1'b0, row} < (ROW_W + 1)'(2 * OUT_H));

  assign buf_rd = line_buf[idx];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic signed [DATA_W-1:0] held;
    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] mx;

    assign held = buf_rd[k*DATA_W +: DATA_W];
    assign pix  = in_data[k*DATA_W +: DATA_W];
    assign mx   = (held > pix) ? held : pix;
    assign merged[k*DATA_W +: DATA_W] = mx;
`ifdef MAXPOOL_RELU_EN
    assign pooled[k*DATA_W +: DATA_W] = mx[DATA_W-1] ? '0 : mx;
`else
    assign pooled[k*DATA_W +: DATA_W] = mx;
`endif
  end

  // Partial window maxima per output column; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (accept && in_pool && !window_end) begin
      if (!row[0] && !col[0]) begin
        line_buf[idx] <= in_data;
      end else begin
        line_buf[idx] <= merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        // A fresh result overrides the clear from a same-cycle transfer.
        if (in_pool && window_end) begin
          out_data  <= pooled;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_relu_stream.sv
// Scoreboard bench for maxpool2x2_relu_stream on a 5x3 two-channel frame.
// Expected pooled values are hand-computed raw maxima; ReLU follows MAXPOOL_RELU_EN.
module tb_maxpool2x2_relu_stream;

  localparam int DW = 12;
  localparam int CH = 2;
  localparam int IW = 5;
  localparam int IH = 3;
  localparam int NPIX = IW * IH;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CH*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH*DW-1:0] out_data;
  logic            frame_done;

  typedef struct {
    logic [CH*DW-1:0] data;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   n_out;
  int   n_fd;
  int   stalls;
  int   mode;

  maxpool2x2_relu_stream #(
    .DATA_W   (DW),
    .CHANNELS (CH),
    .IN_W     (IW),
    .IN_H     (IH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int relu_exp(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Downstream readiness: 0 = always ready, 1 = ready one cycle in three, 2 = stalled.
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput();
    exp_t e;
    checks++;
    n_out++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_output: got %h, required no output", out_data);
    end else begin
      e = exp_q.pop_front();
      if (out_data !== e.data) begin
        errors++;
        $display("[TB] FAIL out_data: got %h, required %h", out_data, e.data);
      end
      if (e.cyc >= 0) begin
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL out_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (out_valid && out_ready) begin
          checkOutput();
        end else if (out_valid) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_ready_stall: got %b, required 0", in_ready);
          end
          if (exp_q.size() > 0) begin
            checks++;
            if (out_data !== exp_q[0].data) begin
              errors++;
              $display("[TB] FAIL hold_data: got %h, required %h", out_data, exp_q[0].data);
            end
          end
        end
        if (frame_done === 1'b1) begin
          checks++;
          n_fd++;
          if (fd_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_frame_done: at cycle %0d, required none", cyc);
          end else begin
            int want;
            want = fd_q.pop_front();
            if (cyc != want) begin
              errors++;
              $display("[TB] FAIL frame_done_cycle: got %0d, required %0d", cyc, want);
            end
          end
        end
      end
    end
  end

  // Sends the first n_pix pixels of frame sel; the first n_exp windows are expected out.
  task automatic applyStimulus(input int sel, input int n_pix, input int n_exp);
    int  c0[NPIX];
    int  c1[NPIX];
    int  e0[2];
    int  e1[2];
    exp_t e;
    case (sel)
      0: begin
        for (int i = 0; i < NPIX; i++) begin
          c0[i] = i;
          c1[i] = -i;
        end
        e0 = '{6, 8};
        e1 = '{0, -2};
      end
      1: begin
        c0 = '{2047, -2048, -2048, -2048, 2047,
               0, 1, -2048, -2048, 2047,
               2047, 2047, 2047, 2047, 2047};
        c1 = '{-2048, -2048, -1, -2048, 2047,
               -2048, -2048, -5, -3, 2047,
               2047, 2047, 2047, 2047, 2047};
        e0 = '{2047, -2048};
        e1 = '{-2048, -1};
      end
      default: begin
        c0 = '{3, -1, -5, -6, 100,
               -2, 9, -4, -8, 100,
               50, 50, 50, 50, 50};
        c1 = '{10, 20, 30, 40, 0,
               15, 5, 45, 25, 0,
               0, 0, 0, 0, 0};
        e0 = '{9, -4};
        e1 = '{20, 45};
      end
    endcase
    for (int p = 0; p < n_pix; p++) begin
      int r;
      int c;
      bit done;
      r = p / IW;
      c = p % IW;
      done = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {DW'(c1[p]), DW'(c0[p])};
      for (int t = 0; t < 200 && !done; t++) begin
        if (t > 0) @(negedge clk);
        #4;
        if (in_ready) begin
          done = 1'b1;
          if (r == 1 && (c % 2) == 1 && (c / 2) < n_exp) begin
            e.data = {DW'(relu_exp(e1[c/2])), DW'(relu_exp(e0[c/2]))};
            e.cyc  = (mode == 0) ? cyc + 1 : -1;
            exp_q.push_back(e);
          end
          if (p == NPIX - 1) fd_q.push_back(cyc + 1);
        end else begin
          stalls++;
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: pixel %0d not accepted, required acceptance", p);
      end
      @(posedge clk);
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fd_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d outputs and %0d frame_done pending, required 0",
               exp_q.size(), fd_q.size());
    end
  endtask

  task automatic checkReset(input string tag);
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_out_valid: got %b, required 0", tag, out_valid);
    end
    if (frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_frame_done: got %b, required 0", tag, frame_done);
    end
    if (out_data !== '0) begin
      errors++;
      $display("[TB] FAIL %s_out_data: got %h, required 0", tag, out_data);
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_in_ready: got %b, required 1", tag, in_ready);
    end
  endtask

  initial begin
    int o0;
    int f0;
    checks   = 0;
    errors   = 0;
    n_out    = 0;
    n_fd     = 0;
    stalls   = 0;
    mode     = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    checkReset("reset");
    rst_n = 1'b1;

    $display("[TB] streaming with downstream always ready");
    applyStimulus(0, NPIX, 2);
    applyStimulus(1, NPIX, 2);
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] streaming under backpressure");
    mode = 1;
    applyStimulus(2, NPIX, 2);
    applyStimulus(0, NPIX, 2);
    applyStimulus(1, NPIX, 2);
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] reset in the middle of a frame");
    mode = 0;
    applyStimulus(2, 9, 1);
    @(negedge clk);
    mode      = 2;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    #3;
    checkReset("midreset");
    rst_n     = 1'b1;
    mode      = 0;
    out_ready = 1'b1;
    applyStimulus(1, NPIX, 2);
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] two back-to-back frames");
    o0 = n_out;
    f0 = n_fd;
    stalls = 0;
    applyStimulus(0, NPIX, 2);
    applyStimulus(2, NPIX, 2);
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain();
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("[TB] FAIL stream_in_ready: got %0d stalled cycles, required 0", stalls);
    end
    checks++;
    if (n_out - o0 != 4) begin
      errors++;
      $display("[TB] FAIL stream_outputs: got %0d, required 4", n_out - o0);
    end
    checks++;
    if (n_fd - f0 != 2) begin
      errors++;
      $display("[TB] FAIL stream_frame_done: got %0d, required 2", n_fd - f0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
